// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, driver state encoding and width default for
//               the registered 4-bit ALU interface.
// Revision    : 1.0
// ============================================================================
package alu_pkg;

    localparam int WIDTH = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        CAPT   = 3'd3,
        RESP   = 3'd4
    } drv_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_op_driver.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_driver
// Description : Issues one request at a time to a registered ALU, waits out its
//               two-stage result/zero timing and returns a single response.
// Revision    : 1.0
// ============================================================================
module alu_op_driver
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_carry,
    output logic             resp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic             err_flag
);

    drv_state_t       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic             w_logic_op;
    logic             w_result_is_zero;

    // Logic ops leave the ALU carry register untouched, so its value is stale.
    assign w_logic_op       = (r_op == OP_AND) || (r_op == OP_OR);
    assign w_result_is_zero = (alu_result == {WIDTH{1'b0}});

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_opcode = r_op;
    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_ADD;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_carry  <= 1'b0;
            resp_zero   <= 1'b0;
            op_count    <= '0;
            err_flag    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_op    <= req_op;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    r_state <= CAPT;
                end
                CAPT: begin
                    resp_result <= alu_result;
                    resp_zero   <= alu_zero;
                    resp_carry  <= w_logic_op ? 1'b0 : alu_carry;
                    resp_valid  <= 1'b1;
                    if (alu_zero != w_result_is_zero) begin
                        err_flag <= 1'b1;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        op_count   <= op_count + 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : alu_op_driver
`default_nettype wire

// File: tb/tb_alu_op_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_driver
// Description : Directed bench for alu_op_driver with a registered ALU model,
//               a transaction-level reference model and literal expectations.
// Revision    : 1.0
// ============================================================================
module tb_alu_op_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_a;
    logic [3:0]  req_b;
    logic [1:0]  req_op;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [1:0]  alu_opcode;
    logic [3:0]  alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_result;
    logic        resp_carry;
    logic        resp_zero;
    logic        busy;
    logic [15:0] op_count;
    logic        err_flag;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;
    logic fault  = 1'b0;

    alu_op_driver #(.WIDTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_carry(resp_carry), .resp_zero(resp_zero),
        .busy(busy), .op_count(op_count), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    // Registered ALU: result/carry one edge after operands, zero one edge later.
    logic [3:0] alu_res_q = 4'd0;
    logic       alu_c_q   = 1'b0;
    logic       alu_z_q   = 1'b0;
    logic [4:0] alu_t;
    always @(posedge clk) begin
        alu_t = 5'd0;
        case (alu_opcode)
            2'b00: begin alu_t = {1'b0, alu_a} + {1'b0, alu_b}; alu_res_q <= alu_t[3:0]; alu_c_q <= alu_t[4]; end
            2'b01: begin alu_t = {1'b0, alu_a} - {1'b0, alu_b}; alu_res_q <= alu_t[3:0]; alu_c_q <= alu_t[4]; end
            2'b10: alu_res_q <= alu_a & alu_b;
            default: alu_res_q <= alu_a | alu_b;
        endcase
        alu_z_q <= (alu_res_q == 4'd0);
    end
    assign alu_result = alu_res_q;
    assign alu_carry  = alu_c_q;
    assign alu_zero   = fault ? 1'b0 : alu_z_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: phase 0 idle, 1 computing, 2 response held.
    int          m_phase = 0;
    int          m_wait  = 0;
    logic [3:0]  m_a = 4'd0, m_b = 4'd0, m_res = 4'd0;
    logic [1:0]  m_op = 2'd0;
    logic        m_c = 1'b0, m_z = 1'b0, m_err = 1'b0, m_true_z;
    logic [15:0] m_cnt = 16'd0;
    logic [4:0]  m_sum;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_cnt = 16'd0; m_err = 1'b0;
            m_a = 4'd0; m_b = 4'd0; m_op = 2'd0;
        end else begin
            case (m_phase)
                0: if (req_valid) begin
                    m_a = req_a; m_b = req_b; m_op = req_op;
                    m_phase = 1; m_wait = 3;
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        case (m_op)
                            2'b00: begin m_sum = {1'b0, m_a} + {1'b0, m_b}; m_res = m_sum[3:0]; m_c = m_sum[4]; end
                            2'b01: begin m_sum = {1'b0, m_a} - {1'b0, m_b}; m_res = m_sum[3:0]; m_c = m_sum[4]; end
                            2'b10: begin m_res = m_a & m_b; m_c = 1'b0; end
                            default: begin m_res = m_a | m_b; m_c = 1'b0; end
                        endcase
                        m_true_z = (m_res == 4'd0);
                        m_z = fault ? 1'b0 : m_true_z;
                        if (m_z != m_true_z) m_err = 1'b1;
                        m_phase = 2;
                    end
                end
                default: if (resp_ready) begin
                    m_phase = 0; m_cnt = m_cnt + 16'd1;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_req_ready", 32'(req_ready), 32'(m_phase == 0));
            chk("m_busy", 32'(busy), 32'(m_phase != 0));
            chk("m_resp_valid", 32'(resp_valid), 32'(m_phase == 2));
            chk("m_op_count", 32'(op_count), 32'(m_cnt));
            chk("m_err_flag", 32'(err_flag), 32'(m_err));
            if (m_phase != 0) begin
                chk("m_alu_a", 32'(alu_a), 32'(m_a));
                chk("m_alu_b", 32'(alu_b), 32'(m_b));
                chk("m_alu_op", 32'(alu_opcode), 32'(m_op));
            end
            if (m_phase == 2) begin
                chk("m_resp_result", 32'(resp_result), 32'(m_res));
                chk("m_resp_carry", 32'(resp_carry), 32'(m_c));
                chk("m_resp_zero", 32'(resp_zero), 32'(m_z));
            end
        end
    end

    // Issue one op from IDLE (at #1 after posedge), check latency, hold, drain.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                         input int hold, input logic [3:0] er, input logic ec, input logic ez);
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        // Junk presented while busy must be ignored.
        req_a = ~a; req_b = ~b; req_op = ~op;
        repeat (2) @(posedge clk);
        #1 chk("early_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("lat_valid", 32'(resp_valid), 32'd1);
        chk("lit_result", 32'(resp_result), 32'(er));
        chk("lit_carry", 32'(resp_carry), 32'(ec));
        chk("lit_zero", 32'(resp_zero), 32'(ez));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_result", 32'(resp_result), 32'(er));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("drain_req_ready", 32'(req_ready), 32'd1);
        chk("drain_valid", 32'(resp_valid), 32'd0);
    endtask

    // Start ADD 1+1 and reset after `edges` further edges (1: SETTLE, 3: RESP).
    task automatic reset_during(input int edges, input logic [15:0] cnt_before);
        req_a = 4'd1; req_b = 4'd1; req_op = 2'b00; req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (edges) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_count", 32'(op_count), 32'(cnt_before));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 chk("rst_no_resp", 32'(resp_valid), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_a = 4'd0; req_b = 4'd0; req_op = 2'd0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(resp_valid), 32'd0);
        chk("reset_count", 32'(op_count), 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_result", 32'(resp_result), 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        reset_during(1, 16'd0);
        reset_during(3, 16'd0);

        do_op(4'd9, 4'd8, 2'b00, 0, 4'h1, 1'b1, 1'b0);
        chk("count_after_first", 32'(op_count), 32'd1);
        do_op(4'd3, 4'd5, 2'b01, 0, 4'hE, 1'b1, 1'b0);
        do_op(4'd5, 4'd5, 2'b01, 0, 4'h0, 1'b0, 1'b1);
        do_op(4'hF, 4'h1, 2'b00, 0, 4'h0, 1'b1, 1'b1);
        do_op(4'hA, 4'h5, 2'b10, 0, 4'h0, 1'b0, 1'b1);
        do_op(4'd2, 4'd3, 2'b00, 5, 4'h5, 1'b0, 1'b0);

        fault = 1'b1;
        do_op(4'h0, 4'h0, 2'b11, 0, 4'h0, 1'b0, 1'b0);
        fault = 1'b0;
        chk("err_set", 32'(err_flag), 32'd1);
        do_op(4'hA, 4'h5, 2'b11, 0, 4'hF, 1'b0, 1'b0);
        do_op(4'd7, 4'd2, 2'b01, 0, 4'h5, 1'b0, 1'b0);
        do_op(4'hF, 4'h3, 2'b10, 0, 4'h3, 1'b0, 1'b0);
        chk("err_sticky", 32'(err_flag), 32'd1);
        chk("final_count", 32'(op_count), 32'd10);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_op_driver
`default_nettype wire
